// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central controller.
// The master side raises stall requests and redirect events.
// The slave side (pipe_ctrl) returns the stall vector, flush and counters.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  // Requests from the stages
  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  // Redirect events committed in MEM
  logic             excp_valid;
  logic [31:0]      excp_vec;
  logic             eret_valid;
  logic [31:0]      epc;
  // Counter maintenance
  logic             cnt_clr;
  // Controller responses
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             refilling;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_timeout;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excp_valid, excp_vec, eret_valid, epc, cnt_clr,
    input  stall, flush, new_pc, refilling, stall_cnt, stall_timeout
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_valid, excp_vec, eret_valid, epc, cnt_clr,
    output stall, flush, new_pc, refilling, stall_cnt, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage core.
// It maps per-stage stall requests onto the PC/inter-stage stall vector.
// On an exception or eret it issues a one-cycle flush with the redirect PC,
// then spends REFILL_CYC cycles injecting bubbles while fetch redirects.
// It also keeps a saturating stall-cycle counter and a sticky stall watchdog.
module pipe_ctrl #(
  parameter int REFILL_CYC = 2,
  parameter int MAX_STALL  = 1024,
  parameter int CNT_W      = 32
) (
  input  logic         clk,
  input  logic         rst,   // asynchronous, active-low
  pipe_ctrl_if.slave   bus
);

  localparam int RC_W = (REFILL_CYC > 1) ? $clog2(REFILL_CYC) : 1;
  localparam int RL_W = $clog2(MAX_STALL);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFILL_CYC - 1);
  localparam logic [RL_W-1:0] RL_LAST = RL_W'(MAX_STALL - 1);

  // Stall vector encodings, bit0 = pc ... bit5 = wb (wb never stops)
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  // During refill the PC advances on the new path while IF/ID holds a bubble
  localparam logic [5:0] STALL_FILL = 6'b000010;

  typedef enum logic {
    ST_RUN,
    ST_REFILL
  } state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [RL_W-1:0]   rl_q, rl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              redirect;
  logic [5:0]        req_stall;
  logic [5:0]        stall_vec;
  logic [31:0]       redirect_pc;
  logic              refill_flag;

  // Request priority: the deepest requesting stage freezes everything upstream
  always_comb begin
    req_stall = STALL_NONE;
    if (bus.stallreq_mem) begin
      req_stall = STALL_MEM;
    end else if (bus.stallreq_ex) begin
      req_stall = STALL_EX;
    end else if (bus.stallreq_id) begin
      req_stall = STALL_ID;
    end else if (bus.stallreq_if) begin
      req_stall = STALL_IF;
    end
  end

  // Redirect target selection; exception outranks eret in the same cycle
  always_comb begin
    redirect    = bus.excp_valid | bus.eret_valid;
    redirect_pc = 32'h0;
    if (bus.excp_valid) begin
      redirect_pc = bus.excp_vec;
    end else if (bus.eret_valid) begin
      redirect_pc = bus.epc;
    end
  end

  // Next-state and stall outputs of the RUN/REFILL controller
  always_comb begin
    state_d     = state_q;
    rc_d        = rc_q;
    stall_vec   = STALL_NONE;
    refill_flag = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        stall_vec = req_stall;
        if (redirect) begin
          state_d = ST_REFILL;
          rc_d    = '0;
        end
      end
      ST_REFILL: begin
        // Stages were just emptied by the flush, so their requests are stale
        refill_flag = 1'b1;
        stall_vec   = STALL_FILL;
        if (redirect) begin
          rc_d = '0;
        end else if (rc_q == RC_LAST) begin
          state_d = ST_RUN;
          rc_d    = '0;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        rc_d    = '0;
      end
    endcase
    // A flush kills the stage registers, so nothing may be held that cycle
    if (redirect) begin
      stall_vec = STALL_NONE;
    end
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
    end
  end

  // Stall statistics: saturating total and watchdog run length
  always_comb begin
    cnt_d     = cnt_q;
    rl_d      = rl_q;
    timeout_d = timeout_q;
    if (bus.cnt_clr) begin
      cnt_d     = '0;
      rl_d      = '0;
      timeout_d = 1'b0;
    end else if (stall_vec[0]) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (rl_q == RL_LAST) begin
        // Run length has been at its limit for a full cycle: flag it
        timeout_d = 1'b1;
      end else begin
        rl_d = rl_q + RL_W'(1);
      end
    end else begin
      rl_d = '0;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      rl_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rl_q      <= rl_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.stall         = stall_vec;
  assign bus.flush         = redirect;
  assign bus.new_pc        = redirect_pc;
  assign bus.refilling     = refill_flag;
  assign bus.stall_cnt     = cnt_q;
  assign bus.stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int RC = 2;
  localparam int MS = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(
    .REFILL_CYC(RC),
    .MAX_STALL (MS),
    .CNT_W     (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural model state
  int refill_left;   // remaining bubble cycles after the last redirect
  int run_len;       // consecutive stalled cycles seen so far
  int m_cnt;
  bit m_to;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected stall vector from the rules, given model state and current inputs
  function automatic logic [5:0] exp_stall();
    if (bus.excp_valid || bus.eret_valid) return 6'b000000;
    if (refill_left > 0)                  return 6'b000010;
    if (bus.stallreq_mem)                 return 6'b011111;
    if (bus.stallreq_ex)                  return 6'b001111;
    if (bus.stallreq_id)                  return 6'b000111;
    if (bus.stallreq_if)                  return 6'b000011;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] exp_pc();
    if (bus.excp_valid) return bus.excp_vec;
    if (bus.eret_valid) return bus.epc;
    return 32'h0;
  endfunction

  task automatic model_reset();
    refill_left = 0;
    run_len     = 0;
    m_cnt       = 0;
    m_to        = 1'b0;
  endtask

  // Apply one cycle's inputs (req bits: 0=if 1=id 2=ex 3=mem), let them settle
  task automatic set(input logic [3:0] req, input bit ex, input bit er,
                     input logic [31:0] vec, input logic [31:0] pc, input bit clr);
    bus.stallreq_if  = req[0];
    bus.stallreq_id  = req[1];
    bus.stallreq_ex  = req[2];
    bus.stallreq_mem = req[3];
    bus.excp_valid   = ex;
    bus.eret_valid   = er;
    bus.excp_vec     = vec;
    bus.epc          = pc;
    bus.cnt_clr      = clr;
    #1;
  endtask

  // Check all outputs against the model, clock once, advance the model
  task automatic go();
    logic [5:0] es;
    bit redir;
    es    = exp_stall();
    redir = bus.excp_valid || bus.eret_valid;
    check("stall",     32'(bus.stall),         32'(es));
    check("flush",     32'(bus.flush),         32'(redir));
    check("new_pc",    bus.new_pc,             exp_pc());
    check("refilling", 32'(bus.refilling),     32'(refill_left > 0));
    check("stall_cnt", 32'(bus.stall_cnt),     32'(m_cnt));
    check("timeout",   32'(bus.stall_timeout), 32'(m_to));
    $display("cyc t=%0t req=%b%b%b%b ex=%b er=%b clr=%b stall=%b flush=%b pc=%h refill=%b cnt=%0d to=%b",
             $time, bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if,
             bus.excp_valid, bus.eret_valid, bus.cnt_clr, bus.stall, bus.flush,
             bus.new_pc, bus.refilling, bus.stall_cnt, bus.stall_timeout);
    @(posedge clk);
    if (bus.cnt_clr) begin
      m_cnt = 0; run_len = 0; m_to = 1'b0;
    end else if (es[0]) begin
      m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      run_len = run_len + 1;
      if (run_len >= MS) m_to = 1'b1;
    end else begin
      run_len = 0;
    end
    if (redir)                refill_left = RC;
    else if (refill_left > 0) refill_left = refill_left - 1;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst = 1'b0;
    set(4'b0000, 0, 0, 32'h0, 32'h0, 0);
    check("rst_stall",   32'(bus.stall),     32'h0);
    check("rst_refill",  32'(bus.refilling), 32'h0);
    check("rst_cnt",     32'(bus.stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Priority
    set(4'b0001, 0, 0, 0, 0, 0); check("prio_if",  32'(bus.stall), 32'b000011); go();
    set(4'b0101, 0, 0, 0, 0, 0); check("prio_ex",  32'(bus.stall), 32'b001111); go();
    set(4'b1101, 0, 0, 0, 0, 0); check("prio_mem", 32'(bus.stall), 32'b011111); go();
    set(4'b0000, 0, 0, 0, 0, 0); check("prio_none", 32'(bus.stall), 32'b000000); go();

    // Exception with a pending mem stall, then refill and resume
    set(4'b1000, 1, 0, 32'h20, 32'h0, 0);
    check("excp_flush", 32'(bus.flush), 32'h1);
    check("excp_pc",    bus.new_pc,     32'h20);
    check("excp_stall", 32'(bus.stall), 32'h0);
    go();
    for (int i = 0; i < RC; i++) begin
      set(4'b1000, 0, 0, 0, 0, 0);
      check("refill_flag",  32'(bus.refilling), 32'h1);
      check("refill_stall", 32'(bus.stall),     32'b000010);
      go();
    end
    set(4'b1000, 0, 0, 0, 0, 0);
    check("resume_stall", 32'(bus.stall), 32'b011111);
    go();

    // Eret alone, then eret together with an exception
    set(4'b0000, 0, 1, 32'h0, 32'h1000, 0); check("eret_pc", bus.new_pc, 32'h1000); go();
    set(4'b0000, 1, 1, 32'h20, 32'h1000, 0); check("both_pc", bus.new_pc, 32'h20); go();
    for (int i = 0; i < RC + 1; i++) begin set(4'b0000, 0, 0, 0, 0, 0); go(); end

    // Back-to-back redirects restart the refill
    set(4'b0000, 1, 0, 32'h40, 0, 0); go();
    set(4'b0000, 1, 0, 32'h80, 0, 0); check("b2b_flush", 32'(bus.flush), 32'h1); go();
    set(4'b0000, 0, 0, 0, 0, 0); check("b2b_n2", 32'(bus.refilling), 32'h1); go();
    set(4'b0000, 0, 0, 0, 0, 0); check("b2b_n3", 32'(bus.refilling), 32'h1); go();
    set(4'b0000, 0, 0, 0, 0, 0); check("b2b_n4", 32'(bus.refilling), 32'h0); go();

    // Counters and watchdog
    set(4'b0000, 0, 0, 0, 0, 1); go();
    for (int i = 0; i < MS - 1; i++) begin set(4'b0010, 0, 0, 0, 0, 0); go(); end
    check("wd_before", 32'(bus.stall_timeout), 32'h0);
    set(4'b0010, 0, 0, 0, 0, 0); go();
    check("wd_after", 32'(bus.stall_timeout), 32'h1);
    for (int i = 0; i < 2; i++) begin set(4'b0010, 0, 0, 0, 0, 0); go(); end
    check("cnt_10", 32'(bus.stall_cnt), 32'd10);
    set(4'b0010, 0, 0, 0, 0, 1); go();
    check("clr_cnt", 32'(bus.stall_cnt), 32'h0);
    check("clr_to",  32'(bus.stall_timeout), 32'h0);
    for (int i = 0; i < 20; i++) begin set(4'b0010, 0, 0, 0, 0, 0); go(); end
    check("cnt_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));

    // Asynchronous reset in the middle of a refill
    set(4'b0000, 1, 0, 32'h100, 0, 0); go();
    set(4'b0000, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    #1;
    check("arst_refill",  32'(bus.refilling),     32'h0);
    check("arst_stall",   32'(bus.stall),         32'h0);
    check("arst_cnt",     32'(bus.stall_cnt),     32'h0);
    check("arst_to",      32'(bus.stall_timeout), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    set(4'b0100, 0, 0, 0, 0, 0); check("arst_run", 32'(bus.stall), 32'b001111); go();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rq;
      bit ex, er, clr;
      rq  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      ex  = ($urandom_range(0, 9) == 0);
      er  = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 29) == 0);
      set(rq, ex, er, $urandom, $urandom, clr);
      go();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
